// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM arbiter: default widths, host-queue
// depths, the packed host request layout {wr, addr, wdata} and the
// per-slot state encoding used by the host queue.
package vram_arb_pkg;

    // Default VRAM word-address and word widths.
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Host queue depth: two entries with the FIFO option, otherwise a single
    // holding register.
    localparam int HOST_Q_DEPTH_FIFO = 2;
    localparam int HOST_Q_DEPTH_HOLD = 1;

    // Each queue slot is either holding a request or free.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Host request layout, MSB to LSB: {wr, addr[aw-1:0], wdata[dw-1:0]}.
    function automatic int hreq_width(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

    // Bit position of the write flag inside a packed host request.
    function automatic int hreq_wr_bit(input int aw, input int dw);
        return aw + dw;
    endfunction

    // LSB position of the address field inside a packed host request.
    function automatic int hreq_addr_lsb(input int dw);
        return dw;
    endfunction

endpackage : vram_arb_pkg

// File: rtl/vram_arb_fifo.sv
// Host request queue for the VRAM arbiter, depth 1 or 2.
// Slot 0 is always the head; a pop shifts slot 1 down, and a push lands in
// the first free slot after any pop of the same edge, so simultaneous push
// and pop keep the occupancy unchanged. A push is ignored while full.
module vram_arb_fifo
    import vram_arb_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);

    slot_state_e      state_q [2];
    slot_state_e      state_d [2];
    logic [WIDTH-1:0] data_q  [2];
    logic [WIDTH-1:0] data_d  [2];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign count_o = 2'(state_q[0] == SLOT_FULL) + 2'(state_q[1] == SLOT_FULL);
    assign full    = (count_o == 2'(DEPTH));
    assign empty_o = (state_q[0] == SLOT_EMPTY);
    assign head_o  = data_q[0];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && !full;

    // Next slot contents: apply the pop shift first, then place the push.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (do_pop) begin
            state_d[0] = state_q[1];
            data_d[0]  = data_q[1];
            state_d[1] = SLOT_EMPTY;
        end
        if (do_push) begin
            if (state_d[0] == SLOT_EMPTY) begin
                state_d[0] = SLOT_FULL;
                data_d[0]  = data_i;
            end else if (DEPTH > 1) begin
                state_d[1] = SLOT_FULL;
                data_d[1]  = data_i;
            end
        end
    end

    // Slot occupancy; cleared immediately on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q[0] <= SLOT_EMPTY;
            state_q[1] <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot payloads; only meaningful while the matching slot is full.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule : vram_arb_fifo

// File: rtl/vram_arb.sv
// VRAM arbiter: single-port VRAM shared between a video fetcher with strict
// priority and a queued host port. Host reads return with fixed latency in
// issue order; host writes return nothing.
// Build option: define VRAM_ARB_HOSTFIFO_EN for a 2-entry host queue
// (1 access per cycle); otherwise a 1-entry holding register is used.
module vram_arb
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_sel,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              host_req,
    output logic              host_rdy,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              vram_sel,
    output logic              vram_wr_en,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
);

`ifdef VRAM_ARB_HOSTFIFO_EN
    localparam int Q_DEPTH = HOST_Q_DEPTH_FIFO;
`else
    localparam int Q_DEPTH = HOST_Q_DEPTH_HOLD;
`endif

    localparam int REQ_W    = hreq_width(ADDR_W, DATA_W);
    localparam int WR_BIT   = hreq_wr_bit(ADDR_W, DATA_W);
    localparam int ADDR_LSB = hreq_addr_lsb(DATA_W);

    logic [REQ_W-1:0]  push_req;
    logic [REQ_W-1:0]  head_req;
    logic              q_empty;
    logic [1:0]        q_count;
    logic              push;
    logic              pop;
    logic              head_wr;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic              host_rd_issue;

    logic              vid_valid_q;
    logic              rd_vld_p0_q;
    logic              rd_vld_p1_q;
    logic [DATA_W-1:0] host_rdata_q;
    logic [DATA_W-1:0] host_rdata_d;

    // Host acceptance: room in the queue; issue is never earlier than the
    // cycle after acceptance because requests always pass through the queue.
    assign host_rdy = (q_count < 2'(Q_DEPTH));
    assign push     = host_req && host_rdy;
    assign push_req = {host_wr, host_addr, host_wdata};

    // The queue head issues only in cycles the video fetcher leaves idle.
    assign pop = !vid_sel && !q_empty;

    vram_arb_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .data_i  (push_req),
        .pop_i   (pop),
        .head_o  (head_req),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign head_wr    = head_req[WR_BIT];
    assign head_addr  = head_req[ADDR_LSB +: ADDR_W];
    assign head_wdata = head_req[DATA_W-1:0];

    // VRAM command mux: video wins, otherwise the queue head, otherwise idle.
    always_comb begin
        vram_sel   = 1'b0;
        vram_wr_en = 1'b0;
        vram_addr  = head_addr;
        vram_wdata = head_wdata;
        if (vid_sel) begin
            vram_sel  = 1'b1;
            vram_addr = vid_addr;
        end else if (!q_empty) begin
            vram_sel   = 1'b1;
            vram_wr_en = head_wr;
        end
    end

    assign host_rd_issue = pop && !head_wr;

    // Video data comes straight from the VRAM read port.
    assign vid_data = vram_rdata;

    // Host read data capture: VRAM data is valid one cycle after issue.
    always_comb begin
        host_rdata_d = host_rdata_q;
        if (rd_vld_p0_q) begin
            host_rdata_d = vram_rdata;
        end
    end

    // Valid pipelines for video and host reads, plus the held host read data;
    // reset drops any read still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_valid_q  <= 1'b0;
            rd_vld_p0_q  <= 1'b0;
            rd_vld_p1_q  <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            vid_valid_q  <= vid_sel;
            rd_vld_p0_q  <= host_rd_issue;
            rd_vld_p1_q  <= rd_vld_p0_q;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign vid_valid   = vid_valid_q;
    assign host_rvalid = rd_vld_p1_q;
    assign host_rdata  = host_rdata_q;

endmodule : vram_arb

// File: tb/tb_vram_arb.sv
// Testbench for vram_arb: a small registered VRAM model answers the DUT,
// a table of per-cycle vectors drives and checks it, and hand sequences
// cover the reset-during-read case.
module tb_vram_arb;

`ifdef VRAM_ARB_HOSTFIFO_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk;
    logic        reset_n;
    logic        vid_sel;
    logic [15:0] vid_addr;
    logic [15:0] vid_data;
    logic        vid_valid;
    logic        host_req;
    logic        host_rdy;
    logic        host_wr;
    logic [15:0] host_addr;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;
    logic        host_rvalid;
    logic        vram_sel;
    logic        vram_wr_en;
    logic [15:0] vram_addr;
    logic [15:0] vram_wdata;
    logic [15:0] vram_rdata;

    vram_arb #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vid_sel     (vid_sel),
        .vid_addr    (vid_addr),
        .vid_data    (vid_data),
        .vid_valid   (vid_valid),
        .host_req    (host_req),
        .host_rdy    (host_rdy),
        .host_wr     (host_wr),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .vram_sel    (vram_sel),
        .vram_wr_en  (vram_wr_en),
        .vram_addr   (vram_addr),
        .vram_wdata  (vram_wdata),
        .vram_rdata  (vram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM model: 256 words, word i preset to 0xA000|i, registered read.
    logic [15:0] mem [0:255];
    bit          mem_ready;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
            vram_rdata <= 16'h0000;
            mem_ready  <= 1'b1;
        end else if (vram_sel) begin
            if (vram_wr_en) mem[vram_addr[7:0]] <= vram_wdata;
            else            vram_rdata <= mem[vram_addr[7:0]];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [step %0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        vs;
        logic [15:0] va;
        logic        hr;
        logic        hw;
        logic [15:0] ha;
        logic [15:0] hd;
        int          cnt;
        logic        sel;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic        vvld;
        logic [15:0] vdata;
        logic        rvld;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs[$];
    vec_t cur;

    function automatic void add(
        input logic vs, input logic [15:0] va,
        input logic hr, input logic hw, input logic [15:0] ha, input logic [15:0] hd,
        input int cnt,
        input logic sel, input logic we, input logic [15:0] addr, input logic [15:0] wd,
        input logic vvld, input logic [15:0] vdata,
        input logic rvld, input logic [15:0] rdata);
        vec_t v;
        v.vs = vs; v.va = va; v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
        v.cnt = cnt; v.sel = sel; v.we = we; v.addr = addr; v.wd = wd;
        v.vvld = vvld; v.vdata = vdata; v.rvld = rvld; v.rdata = rdata;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic vs, input logic [15:0] va, input logic hr,
                         input logic hw, input logic [15:0] ha, input logic [15:0] hd);
        vid_sel    = vs;
        vid_addr   = va;
        host_req   = hr;
        host_wr    = hw;
        host_addr  = ha;
        host_wdata = hd;
    endtask

    initial begin
        // ---- vector table --------------------------------------------------
        //   vs va      hr hw ha      hd       cnt sel we addr    wd       vvld vdata    rvld rdata
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'h0);
        // host write 0x1234 -> 0x0010, issued the cycle after acceptance
        add(0, 16'h0, 1, 1, 16'h10, 16'h1234, 0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'h0);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    1,  1, 1, 16'h10, 16'h1234, 0, 16'h0,    0, 16'h0);
        // host read of 0x0010, pulse three cycles after acceptance
        add(0, 16'h0, 1, 0, 16'h10, 16'h0,    0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'h0);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    1,  1, 0, 16'h10, 16'h0,    0, 16'h0,    0, 16'h0);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'h0);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    1, 16'h1234);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'h1234);
        // two video fetches
        add(1, 16'h20,0, 0, 16'h0,  16'h0,    0,  1, 0, 16'h20, 16'h0,    0, 16'h0,    0, 16'h1234);
        add(1, 16'h21,0, 0, 16'h0,  16'h0,    0,  1, 0, 16'h21, 16'h0,    1, 16'hA020, 0, 16'h1234);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    0,  0, 0, 16'h0,  16'h0,    1, 16'hA021, 0, 16'h1234);
        // host read of 0x0030 queued, then 5 cycles of video starve it
        add(0, 16'h0, 1, 0, 16'h30, 16'h0,    0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'h1234);
        for (int i = 0; i < 5; i++)
            add(1, 16'h40 + 16'(i), 0, 0, 16'h0, 16'h0, 1, 1, 0, 16'h40 + 16'(i), 16'h0,
                (i > 0), 16'hA040 + 16'(i) - 16'h1, 0, 16'h1234);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    1,  1, 0, 16'h30, 16'h0,    1, 16'hA044, 0, 16'h1234);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'h1234);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    1, 16'hA030);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'hA030);
        // queued host write held off by one video read, then issued
        add(0, 16'h0, 1, 1, 16'h60, 16'h5555, 0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'hA030);
        add(1, 16'h10,0, 0, 16'h0,  16'h0,    1,  1, 0, 16'h10, 16'h0,    0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    1,  1, 1, 16'h60, 16'h5555, 1, 16'h1234, 0, 16'hA030);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'hA030);
`ifdef VRAM_ARB_HOSTFIFO_EN
        // four back-to-back writes: accepted every cycle, written every cycle
        add(0, 16'h0, 1, 1, 16'h70, 16'h7000, 0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 1, 1, 16'h71, 16'h7001, 1,  1, 1, 16'h70, 16'h7000, 0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 1, 1, 16'h72, 16'h7002, 1,  1, 1, 16'h71, 16'h7001, 0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 1, 1, 16'h73, 16'h7003, 1,  1, 1, 16'h72, 16'h7002, 0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    1,  1, 1, 16'h73, 16'h7003, 0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'hA030);
        // fill the queue under video, then a pop while full refuses the request
        add(1, 16'h1, 1, 1, 16'h80, 16'h8000, 0,  1, 0, 16'h1,  16'h0,    0, 16'h0,    0, 16'hA030);
        add(1, 16'h2, 1, 1, 16'h81, 16'h8001, 1,  1, 0, 16'h2,  16'h0,    1, 16'hA001, 0, 16'hA030);
        add(1, 16'h3, 1, 1, 16'h82, 16'h8002, 2,  1, 0, 16'h3,  16'h0,    1, 16'hA002, 0, 16'hA030);
        add(0, 16'h0, 1, 1, 16'h82, 16'h8002, 2,  1, 1, 16'h80, 16'h8000, 1, 16'hA003, 0, 16'hA030);
        add(0, 16'h0, 1, 1, 16'h82, 16'h8002, 1,  1, 1, 16'h81, 16'h8001, 0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    1,  1, 1, 16'h82, 16'h8002, 0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'hA030);
`else
        // four back-to-back writes: host_rdy alternates, writes every other cycle
        add(0, 16'h0, 1, 1, 16'h70, 16'h7000, 0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 1, 1, 16'h71, 16'h7001, 1,  1, 1, 16'h70, 16'h7000, 0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 1, 1, 16'h71, 16'h7001, 0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 1, 1, 16'h72, 16'h7002, 1,  1, 1, 16'h71, 16'h7001, 0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 1, 1, 16'h72, 16'h7002, 0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 1, 1, 16'h73, 16'h7003, 1,  1, 1, 16'h72, 16'h7002, 0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 1, 1, 16'h73, 16'h7003, 0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    1,  1, 1, 16'h73, 16'h7003, 0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'hA030);
        // full holding register: a pop in the same cycle does not admit the request
        add(1, 16'h1, 1, 1, 16'h80, 16'h8000, 0,  1, 0, 16'h1,  16'h0,    0, 16'h0,    0, 16'hA030);
        add(1, 16'h2, 1, 1, 16'h81, 16'h8001, 1,  1, 0, 16'h2,  16'h0,    1, 16'hA001, 0, 16'hA030);
        add(0, 16'h0, 1, 1, 16'h81, 16'h8001, 1,  1, 1, 16'h80, 16'h8000, 1, 16'hA002, 0, 16'hA030);
        add(0, 16'h0, 1, 1, 16'h81, 16'h8001, 0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    1,  1, 1, 16'h81, 16'h8001, 0, 16'h0,    0, 16'hA030);
        add(0, 16'h0, 0, 0, 16'h0,  16'h0,    0,  0, 0, 16'h0,  16'h0,    0, 16'h0,    0, 16'hA030);
`endif

        // ---- reset state ---------------------------------------------------
        reset_n = 1'b0;
        drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vid_valid",   -1, vid_valid,   1'b0);
        chk("rst_host_rvalid", -1, host_rvalid, 1'b0);
        chk("rst_host_rdata",  -1, host_rdata,  16'h0);
        chk("rst_vram_sel",    -1, vram_sel,    1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // ---- table run -----------------------------------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            cur = vecs[i];
            drive(cur.vs, cur.va, cur.hr, cur.hw, cur.ha, cur.hd);
            @(negedge clk);
            chk("host_rdy",    i, host_rdy,    (cur.cnt < DEPTH) ? 1'b1 : 1'b0);
            chk("vram_sel",    i, vram_sel,    cur.sel);
            chk("vram_wr_en",  i, vram_wr_en,  cur.we);
            if (cur.sel) chk("vram_addr",  i, vram_addr,  cur.addr);
            if (cur.we)  chk("vram_wdata", i, vram_wdata, cur.wd);
            chk("vid_valid",   i, vid_valid,   cur.vvld);
            if (cur.vvld) chk("vid_data", i, vid_data, cur.vdata);
            chk("host_rvalid", i, host_rvalid, cur.rvld);
            chk("host_rdata",  i, host_rdata,  cur.rdata);
            @(posedge clk);
            #1;
        end

        // ---- reset one cycle after a host read issues ----------------------
        drive(0, 16'h0, 1, 0, 16'h10, 16'h0);
        @(negedge clk);
        chk("rr_accept_rdy", 100, host_rdy, 1'b1);
        @(posedge clk);
        #1 drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
        @(negedge clk);
        chk("rr_issue_sel",  101, vram_sel,   1'b1);
        chk("rr_issue_wr",   101, vram_wr_en, 1'b0);
        chk("rr_issue_addr", 101, vram_addr,  16'h10);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("rr_in_rst_rvalid", 102, host_rvalid, 1'b0);
        chk("rr_in_rst_rdata",  102, host_rdata,  16'h0);
        chk("rr_in_rst_vvalid", 102, vid_valid,   1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_post_rvalid", 103 + k, host_rvalid, 1'b0);
            chk("rr_post_rdy",    103 + k, host_rdy,    1'b1);
            chk("rr_post_sel",    103 + k, vram_sel,    1'b0);
            chk("rr_post_rdata",  103 + k, host_rdata,  16'h0);
            @(posedge clk);
            #1;
        end

        // ---- fresh read after reset returns data written earlier -----------
        drive(0, 16'h0, 1, 0, 16'h60, 16'h0);
        @(posedge clk);
        #1 drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
        @(negedge clk);
        chk("pr_issue_addr", 110, vram_addr, 16'h60);
        chk("pr_issue_sel",  110, vram_sel,  1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("pr_no_early_rvalid", 111, host_rvalid, 1'b0);
        @(negedge clk);
        chk("pr_rvalid", 112, host_rvalid, 1'b1);
        chk("pr_rdata",  112, host_rdata,  16'h5555);
        @(negedge clk);
        chk("pr_rvalid_drop", 113, host_rvalid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_vram_arb

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, VRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, VRAM word width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- vid_sel  in  1  video fetch request this cycle
- vid_addr  in  ADDR_W  video fetch address
- vid_data  out  DATA_W  video read data
- vid_valid  out  1  vid_data valid
- host_req  in  1  host request valid
- host_rdy  out  1  host request can be accepted
- host_wr  in  1  1=write, 0=read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  host_rdata valid, one-cycle pulse
- vram_sel  out  1  VRAM select
- vram_wr_en  out  1  VRAM write enable
- vram_addr  out  ADDR_W  VRAM address
- vram_wdata  out  DATA_W  VRAM write data
- vram_rdata  in  DATA_W  VRAM registered read data, valid 1 cycle after address

Function
REQ-005 SHALL accept a host request on a rising clk edge where host_req & host_rdy, storing {wr, addr, wdata} in the host queue; no bypass, so issue is earliest the next cycle.
REQ-006 SHALL give strict priority to video: when vid_sel=1, vram_sel=1, vram_wr_en=0, vram_addr=vid_addr; the queued host request waits.
REQ-007 SHALL issue the queue head when vid_sel=0 and queue is non-empty: vram_sel=1, vram_wr_en=head.wr, vram_addr=head.addr, vram_wdata=head.wdata; the head is popped at that edge.
REQ-008 SHALL drive vram_sel=0, vram_wr_en=0 when neither source is active; vram_* outputs are combinational from vid_* and queue head.
REQ-009 SHALL pass vid_data = vram_rdata combinationally; vid_valid SHALL be a register set to 1 in cycle N+1 for a video issue in cycle N.
REQ-010 SHALL, for a host read issued in cycle N, register vram_rdata at end of N+1 into host_rdata and assert host_rvalid for exactly cycle N+2; host_rdata holds between pulses.
REQ-011 SHALL produce no host_rvalid for host writes.
REQ-012 SHALL return host read data in issue order; multiple reads may be outstanding (fixed latency, 2-stage valid pipeline).
REQ-013 SHALL deassert host_rdy when the queue is full; push and pop in the same edge leave occupancy unchanged.
REQ-014 SHALL allow unbounded host starvation while vid_sel stays high; the queue holds its contents unchanged.
REQ-015 States per queue slot: EMPTY, FULL; transitions only on push/pop as above.

Reset
REQ-016 SHALL, on reset_n=0, immediately clear the queue, vid_valid, host_rvalid, and the read-valid pipeline; host_rdata=0; host_rdy=1 after release.
REQ-017 SHALL discard any in-flight host read on reset; no host_rvalid pulse after release for pre-reset reads.

Configuration
REQ-018 SHALL with VRAM_ARB_HOSTFIFO_EN defined use a 2-entry host queue: host_rdy = (count<2); back-to-back host accesses sustain 1 per cycle.
REQ-019 SHALL without VRAM_ARB_HOSTFIFO_EN use a 1-entry holding register: host_rdy = empty; host throughput at most 1 per 2 cycles.

Structure
REQ-020 SHALL place ADDR_W/DATA_W defaults and the host request field layout {wr, addr, wdata} in a shared package vram_arb_pkg.
REQ-021 SHALL implement the queue as sub-module vram_arb_fifo (depth 1 or 2, push/pop/full/empty/count).

Verification
REQ-022 Host write 0x1234 to 0x0010, vid_sel=0 -> vram_sel=1, vram_wr_en=1, vram_addr=0x0010, vram_wdata=0x1234 one cycle after accept.
REQ-023 Host read of 0x0010 after REQ-022 write -> host_rvalid pulse 3 cycles after accept with host_rdata=0x1234.
REQ-024 vid_sel held high 5 cycles with host read queued -> vram_addr=vid_addr for 5 cycles, host issue in cycle 6, vid_valid high cycles 2..6.
REQ-025 With VRAM_ARB_HOSTFIFO_EN, 4 back-to-back host writes, vid_sel=0 -> host_rdy stays 1, 4 consecutive vram writes; without it -> host_rdy alternates 1/0, writes every other cycle.
REQ-026 Assert reset_n=0 one cycle after host read issue -> host_rvalid never pulses, queue empty, host_rdy=1 after release.
REQ-027 Queue full plus simultaneous pop and host_req -> new request accepted only if host_rdy was 1 that cycle; occupancy count checked each edge.
